// File: rtl/axi4_lite_slave_regs.sv
// AXI4-Lite slave exposing a bank of 32-bit registers.
// Independent write (AW/W/B) and read (AR/R) state machines, byte-strobed
// writes, optional read-only registers sourced from STATUS_IN, and a
// one-cycle write strobe per register.
module axi4_lite_slave_regs #(
  parameter int                    p_ADDRESS_BUS_WIDTH        = 32,
  parameter int                    p_DATA_BUS_WIDTH           = 32,
  parameter int                    p_AXI4_LITE_PROT_BUS_WIDTH = 3,
  parameter int                    p_AXI4_LITE_RESP_BUS_WIDTH = 2,
  parameter int                    p_NUM_REGS                 = 16,
  parameter logic [p_NUM_REGS-1:0] p_RO_MASK                  = '0
) (
  input  logic                                  ACLK,
  input  logic                                  ARESET,
  input  logic [p_ADDRESS_BUS_WIDTH-1:0]        AWADDR,
  input  logic [p_AXI4_LITE_PROT_BUS_WIDTH-1:0] AWPROT,
  input  logic                                  AWVALID,
  output logic                                  AWREADY,
  input  logic [p_DATA_BUS_WIDTH-1:0]           WDATA,
  input  logic [p_DATA_BUS_WIDTH/8-1:0]         WSTRB,
  input  logic                                  WVALID,
  output logic                                  WREADY,
  output logic [p_AXI4_LITE_RESP_BUS_WIDTH-1:0] BRESP,
  output logic                                  BVALID,
  input  logic                                  BREADY,
  input  logic [p_ADDRESS_BUS_WIDTH-1:0]        ARADDR,
  input  logic [p_AXI4_LITE_PROT_BUS_WIDTH-1:0] ARPROT,
  input  logic                                  ARVALID,
  output logic                                  ARREADY,
  output logic [p_DATA_BUS_WIDTH-1:0]           RDATA,
  output logic [p_AXI4_LITE_RESP_BUS_WIDTH-1:0] RRESP,
  output logic                                  RVALID,
  input  logic                                  RREADY,
  output logic [32*p_NUM_REGS-1:0]              REG_OUT,
  output logic [p_NUM_REGS-1:0]                 REG_WR_STB,
  input  logic [32*p_NUM_REGS-1:0]              STATUS_IN
);

  localparam int c_IDX_W = $clog2(p_NUM_REGS);
  localparam logic [p_AXI4_LITE_RESP_BUS_WIDTH-1:0] c_RESP_OKAY   = '0;
  localparam logic [p_AXI4_LITE_RESP_BUS_WIDTH-1:0] c_RESP_SLVERR =
    p_AXI4_LITE_RESP_BUS_WIDTH'(2'b10);

  typedef enum logic {W_IDLE = 1'b0, W_RESP = 1'b1} w_state_e;
  typedef enum logic {R_IDLE = 1'b0, R_RESP = 1'b1} r_state_e;

  // Any set address bit above the register window means no register is hit.
  function automatic logic addr_oor(input logic [p_ADDRESS_BUS_WIDTH-1:0] addr);
    return |addr[p_ADDRESS_BUS_WIDTH-1:c_IDX_W+2];
  endfunction

  // Replace only the byte lanes whose strobe bit is set.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_v;
    for (int k = 0; k < 4; k++) begin
      if (strb[k]) begin
        res[8*k +: 8] = new_v[8*k +: 8];
      end else begin
        res[8*k +: 8] = old_v[8*k +: 8];
      end
    end
    return res;
  endfunction

  w_state_e w_state_q, w_state_d;
  r_state_e r_state_q, r_state_d;
  logic aw_lat_q, aw_lat_d, w_lat_q, w_lat_d;
  logic [p_ADDRESS_BUS_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic bvalid_q, bvalid_d, rvalid_q, rvalid_d;
  logic [p_AXI4_LITE_RESP_BUS_WIDTH-1:0] bresp_q, bresp_d, rresp_q, rresp_d;
  logic [31:0] rdata_q, rdata_d;
  logic [p_NUM_REGS-1:0][31:0] regs_q, regs_d;
  logic [p_NUM_REGS-1:0][31:0] status_s;
  logic [p_NUM_REGS-1:0] wr_stb_q, wr_stb_d;

  logic aw_hs_s, w_hs_s, ar_hs_s, commit_s;
  logic [p_ADDRESS_BUS_WIDTH-1:0] waddr_s;
  logic [31:0] wdata_s;
  logic [3:0]  wstrb_s;
  logic [c_IDX_W-1:0] waddr_idx_s, raddr_idx_s;
  logic unused_s;

  // Ready signals are forced low while reset is held.
  assign AWREADY = ~ARESET & (w_state_q == W_IDLE) & ~aw_lat_q;
  assign WREADY  = ~ARESET & (w_state_q == W_IDLE) & ~w_lat_q;
  assign ARREADY = ~ARESET & (r_state_q == R_IDLE);

  assign aw_hs_s = AWVALID & AWREADY;
  assign w_hs_s  = WVALID & WREADY;
  assign ar_hs_s = ARVALID & ARREADY;

  // Commit uses the latched beat if present, otherwise the live handshake.
  assign waddr_s  = aw_lat_q ? awaddr_q : AWADDR;
  assign wdata_s  = w_lat_q ? wdata_q : WDATA;
  assign wstrb_s  = w_lat_q ? wstrb_q : WSTRB;
  assign commit_s = (w_state_q == W_IDLE) & (aw_lat_q | aw_hs_s) & (w_lat_q | w_hs_s);

  assign waddr_idx_s = waddr_s[c_IDX_W+1:2];
  assign raddr_idx_s = ARADDR[c_IDX_W+1:2];
  assign status_s    = STATUS_IN;

  assign BVALID     = bvalid_q;
  assign BRESP      = bresp_q;
  assign RVALID     = rvalid_q;
  assign RRESP      = rresp_q;
  assign RDATA      = rdata_q;
  assign REG_OUT    = regs_q;
  assign REG_WR_STB = wr_stb_q;

  // PROT and the byte offset within a word carry no meaning here.
  assign unused_s = ^{AWPROT, ARPROT, waddr_s[1:0], ARADDR[1:0]};

  // Write path next state: latch AW/W beats, commit once both are present, hold B until accepted.
  always_comb begin
    w_state_d = w_state_q;
    aw_lat_d  = aw_lat_q;
    w_lat_d   = w_lat_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    regs_d    = regs_q;
    wr_stb_d  = '0;
    case (w_state_q)
      W_IDLE: begin
        if (aw_hs_s) begin
          aw_lat_d = 1'b1;
          awaddr_d = AWADDR;
        end else begin
          aw_lat_d = aw_lat_q;
        end
        if (w_hs_s) begin
          w_lat_d = 1'b1;
          wdata_d = WDATA;
          wstrb_d = WSTRB;
        end else begin
          w_lat_d = w_lat_q;
        end
        if (commit_s) begin
          aw_lat_d  = 1'b0;
          w_lat_d   = 1'b0;
          bvalid_d  = 1'b1;
          w_state_d = W_RESP;
          if (addr_oor(waddr_s)) begin
            bresp_d = c_RESP_SLVERR;
          end else if (p_RO_MASK[waddr_idx_s]) begin
            bresp_d = c_RESP_OKAY;
          end else begin
            bresp_d               = c_RESP_OKAY;
            regs_d[waddr_idx_s]   = merge_bytes(regs_q[waddr_idx_s], wdata_s, wstrb_s);
            wr_stb_d[waddr_idx_s] = 1'b1;
          end
        end else begin
          w_state_d = W_IDLE;
        end
      end
      W_RESP: begin
        if (BREADY) begin
          bvalid_d  = 1'b0;
          w_state_d = W_IDLE;
        end else begin
          bvalid_d  = 1'b1;
        end
      end
      default: begin
        w_state_d = W_IDLE;
        bvalid_d  = 1'b0;
      end
    endcase
  end

  // Read path next state: capture response on AR handshake, hold it until R is accepted.
  always_comb begin
    r_state_d = r_state_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    case (r_state_q)
      R_IDLE: begin
        if (ar_hs_s) begin
          r_state_d = R_RESP;
          rvalid_d  = 1'b1;
          if (addr_oor(ARADDR)) begin
            rdata_d = 32'h0000_0000;
            rresp_d = c_RESP_SLVERR;
          end else if (p_RO_MASK[raddr_idx_s]) begin
            rdata_d = status_s[raddr_idx_s];
            rresp_d = c_RESP_OKAY;
          end else begin
            // regs_q is the pre-write value even if a commit lands on this edge.
            rdata_d = regs_q[raddr_idx_s];
            rresp_d = c_RESP_OKAY;
          end
        end else begin
          rvalid_d = 1'b0;
        end
      end
      R_RESP: begin
        if (RREADY) begin
          rvalid_d  = 1'b0;
          r_state_d = R_IDLE;
        end else begin
          rvalid_d  = 1'b1;
        end
      end
      default: begin
        r_state_d = R_IDLE;
        rvalid_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset abandons any in-flight transaction.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      w_state_q <= W_IDLE;
      r_state_q <= R_IDLE;
      aw_lat_q  <= 1'b0;
      w_lat_q   <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= 32'h0000_0000;
      wstrb_q   <= 4'h0;
      bvalid_q  <= 1'b0;
      bresp_q   <= '0;
      rvalid_q  <= 1'b0;
      rresp_q   <= '0;
      rdata_q   <= 32'h0000_0000;
      regs_q    <= '0;
      wr_stb_q  <= '0;
    end else begin
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
      aw_lat_q  <= aw_lat_d;
      w_lat_q   <= w_lat_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
      regs_q    <= regs_d;
      wr_stb_q  <= wr_stb_d;
    end
  end

endmodule

// File: tb/tb_axi4_lite_slave_regs.sv
// Self-checking bench for axi4_lite_slave_regs: directed scenarios followed by
// randomized transactions, checked against a word-array reference model.
module tb_axi4_lite_slave_regs;

  localparam int          N  = 16;
  localparam logic [15:0] RO = 16'h8000;

  logic         ACLK = 1'b0;
  logic         ARESET;
  logic [31:0]  AWADDR, WDATA, ARADDR, RDATA;
  logic [2:0]   AWPROT, ARPROT;
  logic [3:0]   WSTRB;
  logic         AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic         ARVALID, ARREADY, RVALID, RREADY;
  logic [1:0]   BRESP, RRESP;
  logic [511:0] REG_OUT, STATUS_IN;
  logic [15:0]  REG_WR_STB;

  logic [31:0] model  [N];
  logic [31:0] status [N];
  int          n_vec = 0;
  int          n_err = 0;
  logic [1:0]  exp_bresp;

  always #5 ACLK = ~ACLK;

  axi4_lite_slave_regs #(
    .p_ADDRESS_BUS_WIDTH(32), .p_DATA_BUS_WIDTH(32),
    .p_AXI4_LITE_PROT_BUS_WIDTH(3), .p_AXI4_LITE_RESP_BUS_WIDTH(2),
    .p_NUM_REGS(N), .p_RO_MASK(RO)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .AWADDR(AWADDR), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .REG_OUT(REG_OUT), .REG_WR_STB(REG_WR_STB), .STATUS_IN(STATUS_IN)
  );

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] model_pack();
    logic [511:0] v;
    for (int i = 0; i < N; i++) v[32*i +: 32] = model[i];
    return v;
  endfunction

  // Reference read: {resp, data}
  function automatic logic [33:0] ref_read(input logic [31:0] addr);
    int idx;
    idx = int'((addr / 4) % 16);
    if (addr >= 32'd64) return {2'b10, 32'h0};
    if (RO[idx])        return {2'b00, status[idx]};
    return {2'b00, model[idx]};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) model[i] = 32'h0;
  endtask

  // Drive AW and W with a skew (lead>0: W first by lead cycles), check commit.
  task automatic write_issue(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input int lead);
    int aw_t, w_t, c, idx;
    bit aw_done, w_done, aw_fire, w_fire;
    logic [15:0] exp_stb;
    aw_t = (lead > 0) ? lead : 0;
    w_t  = (lead < 0) ? -lead : 0;
    c = 0; aw_done = 1'b0; w_done = 1'b0;
    while (!(aw_done && w_done) && c < 30) begin
      @(negedge ACLK);
      AWADDR  = addr;  WDATA = data; WSTRB = strb;
      AWVALID = (!aw_done && c >= aw_t);
      WVALID  = (!w_done && c >= w_t);
      check("bvalid_early", BVALID, 1'b0);
      if (w_done)  check("wready_after_w", WREADY, 1'b0);
      if (aw_done) check("awready_after_aw", AWREADY, 1'b0);
      aw_fire = AWVALID && AWREADY;
      w_fire  = WVALID && WREADY;
      @(posedge ACLK);
      if (aw_fire) aw_done = 1'b1;
      if (w_fire)  w_done  = 1'b1;
      c++;
    end
    check("wr_handshakes", {aw_done, w_done}, 2'b11);
    idx = int'((addr / 4) % 16);
    exp_stb = 16'h0;
    if (addr >= 32'd64) begin
      exp_bresp = 2'b10;
    end else begin
      exp_bresp = 2'b00;
      if (!RO[idx]) begin
        exp_stb = 16'h1 << idx;
        for (int k = 0; k < 4; k++)
          if (strb[k]) model[idx][8*k +: 8] = data[8*k +: 8];
      end
    end
    @(negedge ACLK);
    AWVALID = 1'b0; WVALID = 1'b0;
    check("bvalid", BVALID, 1'b1);
    check("bresp", BRESP, exp_bresp);
    check("wr_stb_pulse", REG_WR_STB, exp_stb);
    check("reg_out_after_wr", REG_OUT, model_pack());
    @(negedge ACLK);
    check("wr_stb_clear", REG_WR_STB, 16'h0);
  endtask

  // Hold BREADY low for 'hold' cycles while offering a new AW, then accept B.
  task automatic b_complete(input int hold);
    for (int i = 0; i < hold; i++) begin
      AWVALID = 1'b1; AWADDR = 32'h0;
      check("b_hold_bvalid", BVALID, 1'b1);
      check("b_hold_bresp", BRESP, exp_bresp);
      check("b_hold_awready", AWREADY, 1'b0);
      check("b_hold_wready", WREADY, 1'b0);
      @(negedge ACLK);
    end
    AWVALID = 1'b0; BREADY = 1'b1;
    @(negedge ACLK);
    BREADY = 1'b0;
    check("bvalid_drop", BVALID, 1'b0);
    check("awready_back", AWREADY, 1'b1);
  endtask

  task automatic do_read(input logic [31:0] addr, input int hold);
    int c;
    bit fired;
    logic [33:0] e;
    c = 0; fired = 1'b0;
    e = ref_read(addr);
    while (!fired && c < 30) begin
      @(negedge ACLK);
      ARVALID = 1'b1; ARADDR = addr;
      fired = ARREADY;
      @(posedge ACLK);
      c++;
    end
    check("ar_handshake", fired, 1'b1);
    @(negedge ACLK);
    ARVALID = 1'b0;
    check("rvalid", RVALID, 1'b1);
    check("rdata", RDATA, e[31:0]);
    check("rresp", RRESP, e[33:32]);
    for (int i = 0; i < hold; i++) begin
      @(negedge ACLK);
      check("r_hold_rvalid", RVALID, 1'b1);
      check("r_hold_rdata", RDATA, e[31:0]);
      check("r_hold_rresp", RRESP, e[33:32]);
    end
    RREADY = 1'b1;
    @(negedge ACLK);
    RREADY = 1'b0;
    check("rvalid_drop", RVALID, 1'b0);
    check("arready_back", ARREADY, 1'b1);
  endtask

  initial begin
    logic [31:0] old_v, a, d;
    ARESET = 1'b1;
    AWADDR = 32'h0; AWPROT = 3'h0; AWVALID = 1'b0;
    WDATA = 32'h0; WSTRB = 4'h0; WVALID = 1'b0; BREADY = 1'b0;
    ARADDR = 32'h0; ARPROT = 3'h0; ARVALID = 1'b0; RREADY = 1'b0;
    for (int i = 0; i < N; i++) status[i] = $urandom();
    status[15] = 32'hCAFE_F00D;
    for (int i = 0; i < N; i++) STATUS_IN[32*i +: 32] = status[i];
    model_reset();

    // Reset state
    repeat (3) @(negedge ACLK);
    check("rst_awready", AWREADY, 1'b0);
    check("rst_wready", WREADY, 1'b0);
    check("rst_arready", ARREADY, 1'b0);
    ARESET = 1'b0;
    #1;
    check("rst_bvalid", BVALID, 1'b0);
    check("rst_rvalid", RVALID, 1'b0);
    check("rst_rdata", RDATA, 32'h0);
    check("rst_resp", {BRESP, RRESP}, 4'h0);
    check("rst_reg_out", REG_OUT, 512'h0);
    check("rst_wr_stb", REG_WR_STB, 16'h0);
    check("rst_awready_idle", AWREADY, 1'b1);

    // Read after reset
    do_read(32'h08, 0);

    // Byte-strobed merge
    write_issue(32'h04, 32'h1122_3344, 4'hF, 0);
    b_complete(0);
    write_issue(32'h04, 32'hAABB_CCDD, 4'b0101, 0);
    b_complete(0);
    check("merge_reg1", REG_OUT[63:32], 32'h11BB_33DD);
    do_read(32'h04, 2);

    // W three cycles ahead of AW, then AW ahead of W
    write_issue(32'h0C, 32'h5A5A_A5A5, 4'hF, 3);
    b_complete(0);
    write_issue(32'h08, 32'h0BAD_BEEF, 4'hF, -2);
    b_complete(0);

    // Back-pressured B channel
    write_issue(32'h10, 32'hDEAD_0010, 4'hF, 0);
    b_complete(5);

    // Out of range
    write_issue(32'h40, 32'hFFFF_FFFF, 4'hF, 0);
    b_complete(0);
    do_read(32'h40, 0);

    // Read-only register
    write_issue(32'h3C, 32'h1234_5678, 4'hF, 1);
    b_complete(0);
    check("ro_reg_zero", REG_OUT[511:480], 32'h0);
    do_read(32'h3C, 1);

    // Zero strobe still pulses
    write_issue(32'h14, 32'hFFFF_FFFF, 4'h0, 0);
    b_complete(0);

    // Same-edge read and write of one register
    @(negedge ACLK);
    old_v = model[4];
    AWVALID = 1'b1; AWADDR = 32'h10; WVALID = 1'b1; WDATA = 32'h7777_8888; WSTRB = 4'hF;
    ARVALID = 1'b1; ARADDR = 32'h10;
    @(negedge ACLK);
    AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
    model[4] = 32'h7777_8888;
    check("rw_same_rdata", RDATA, old_v);
    check("rw_same_valids", {RVALID, BVALID}, 2'b11);
    check("rw_same_reg_out", REG_OUT, model_pack());
    BREADY = 1'b1; RREADY = 1'b1;
    @(negedge ACLK);
    BREADY = 1'b0; RREADY = 1'b0;
    check("rw_same_drop", {RVALID, BVALID}, 2'b00);

    // Reset while in W_RESP
    write_issue(32'h18, 32'hC0DE_0018, 4'hF, 0);
    ARESET = 1'b1;
    #1;
    check("rst_wresp_awready", AWREADY, 1'b0);
    @(negedge ACLK);
    model_reset();
    check("rst_wresp_bvalid", BVALID, 1'b0);
    check("rst_wresp_reg_out", REG_OUT, model_pack());
    ARESET = 1'b0;
    #1;
    check("rst_wresp_awready_back", AWREADY, 1'b1);

    // Reset with AW latched: stale address must not be committed later
    @(negedge ACLK);
    AWVALID = 1'b1; AWADDR = 32'h20;
    @(negedge ACLK);
    AWVALID = 1'b0;
    check("aw_latched", AWREADY, 1'b0);
    ARESET = 1'b1;
    @(negedge ACLK);
    ARESET = 1'b0;
    write_issue(32'h24, 32'h2424_2424, 4'hF, 2);
    b_complete(0);

    // Randomized traffic
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 7) == 0) a = $urandom() | 32'h40;
      else a = ($urandom_range(0, 15) * 4) + $urandom_range(0, 3);
      d = $urandom();
      if ($urandom_range(0, 1) == 1) begin
        write_issue(a, d, 4'($urandom_range(0, 15)), $urandom_range(0, 6) - 3);
        b_complete($urandom_range(0, 2));
      end else begin
        do_read(a, $urandom_range(0, 2));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
